// File: rtl/mem_stage_lsu_if.sv
// Data-cache port of the MEM-stage load/store unit.
// The LSU is the master. The data cache, or a bench model of it, is the slave.
interface mem_stage_lsu_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: one data-cache transaction per memory op, pipeline stalled until dmem_resp.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the cache and flag misalign_o.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        mem_read_d_i,
    input  logic        mem_write_d_i,
    input  logic [2:0]  load_funct3_i,
    input  logic [2:0]  store_funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    mem_stage_lsu_if.master dmem
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  lf3_q, lf3_d;
    logic        is_load_q, is_load_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_address_q, dmem_address_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_mbe_q, dmem_mbe_d;
    logic [31:0] load_data_q, load_data_d;

    logic        start;
    logic [31:0] st_wdata;
    logic [3:0]  st_mbe;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Gating with rst_n keeps stall low while reset is held, even with a request pending.
    assign start = rst_n & req_valid_i & (mem_read_d_i | mem_write_d_i);

    // Store lanes are resolved at accept, so only the shifted data is kept.
    always_comb begin
        st_wdata = store_data_i;
        st_mbe   = 4'b1111;
        case (store_funct3_i)
            3'b000: begin
                st_wdata = store_data_i << {addr_i[1:0], 3'b000};
                st_mbe   = 4'b0001 << addr_i[1:0];
            end
            3'b001: begin
                st_wdata = store_data_i << {addr_i[1], 4'b0000};
                st_mbe   = 4'b0011 << {addr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign ld_byte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (lf3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic acc_byte, acc_half, misaligned;

    // A load with a read/write conflict is sized by its load funct3.
    assign acc_byte   = mem_read_d_i ? (load_funct3_i[1:0] == 2'b00) : (store_funct3_i == 3'b000);
    assign acc_half   = mem_read_d_i ? (load_funct3_i[1:0] == 2'b01) : (store_funct3_i == 3'b001);
    assign misaligned = acc_half ? addr_i[0] : (!acc_byte && (addr_i[1:0] != 2'b00));
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        lf3_d          = lf3_q;
        is_load_d      = is_load_q;
        dmem_read_d    = dmem_read_q;
        dmem_write_d   = dmem_write_q;
        dmem_address_d = dmem_address_q;
        dmem_wdata_d   = dmem_wdata_q;
        dmem_mbe_d     = dmem_mbe_q;
        load_data_d    = load_data_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d     = misalign_q;
`endif
        stall_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_o        = 1'b1;
                    off_d          = addr_i[1:0];
                    lf3_d          = load_funct3_i;
                    is_load_d      = mem_read_d_i;
                    dmem_read_d    = mem_read_d_i;
                    dmem_write_d   = !mem_read_d_i;
                    dmem_address_d = {addr_i[31:2], 2'b00};
                    dmem_wdata_d   = mem_read_d_i ? 32'd0 : st_wdata;
                    dmem_mbe_d     = mem_read_d_i ? 4'd0 : st_mbe;
                    state_d        = S_BUSY;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        dmem_read_d    = 1'b0;
                        dmem_write_d   = 1'b0;
                        dmem_address_d = 32'd0;
                        dmem_wdata_d   = 32'd0;
                        dmem_mbe_d     = 4'd0;
                        load_data_d    = 32'd0;
                        misalign_d     = 1'b1;
                        state_d        = S_DONE;
                    end
`endif
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (dmem.dmem_resp) begin
                    dmem_read_d    = 1'b0;
                    dmem_write_d   = 1'b0;
                    dmem_address_d = 32'd0;
                    dmem_wdata_d   = 32'd0;
                    dmem_mbe_d     = 4'd0;
                    load_data_d    = is_load_q ? load_ext : 32'd0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
`ifdef MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            off_q          <= 2'd0;
            lf3_q          <= 3'd0;
            is_load_q      <= 1'b0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_address_q <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            dmem_mbe_q     <= 4'd0;
            load_data_q    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            off_q          <= off_d;
            lf3_q          <= lf3_d;
            is_load_q      <= is_load_d;
            dmem_read_q    <= dmem_read_d;
            dmem_write_q   <= dmem_write_d;
            dmem_address_q <= dmem_address_d;
            dmem_wdata_q   <= dmem_wdata_d;
            dmem_mbe_q     <= dmem_mbe_d;
            load_data_q    <= load_data_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= misalign_d;
`endif
        end
    end

    assign done_o            = (state_q == S_DONE);
    assign load_data_o       = load_data_q;
    assign dmem.dmem_read    = dmem_read_q;
    assign dmem.dmem_write   = dmem_write_q;
    assign dmem.dmem_address = dmem_address_q;
    assign dmem.dmem_wdata   = dmem_wdata_q;
    assign dmem.dmem_mbe     = dmem_mbe_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table of loads/stores with a cycle-level cache model,
// plus hand-written reset, idle and back-to-back sequences.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read_d = 1'b0;
    logic        mem_write_d = 1'b0;
    logic [2:0]  load_funct3 = 3'd0;
    logic [2:0]  store_funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        stall, done, misalign;
    logic [31:0] load_data;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .mem_read_d_i   (mem_read_d),
        .mem_write_d_i  (mem_write_d),
        .load_funct3_i  (load_funct3),
        .store_funct3_i (store_funct3),
        .addr_i         (addr),
        .store_data_i   (store_data),
        .stall_o        (stall),
        .done_o         (done),
        .load_data_o    (load_data),
        .misalign_o     (misalign),
        .dmem           (dmem_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  lf3;
        logic [2:0]  sf3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic        chain;
        logic [31:0] e_addr;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] lf3,
                                input logic [2:0] sf3, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rdat, input int w, input logic ch,
                                input logic [31:0] ea, input logic [3:0] em,
                                input logic [31:0] ew, input logic [31:0] el);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lf3 = lf3; v.sf3 = sf3; v.addr = a; v.sdata = sd;
        v.rdata = rdat; v.waits = w; v.chain = ch;
        v.e_addr = ea; v.e_mbe = em; v.e_wdata = ew; v.e_ld = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_rd"},    32'(dmem_bus.dmem_read), 0);
        chk({tag, "_wr"},    32'(dmem_bus.dmem_write), 0);
        chk({tag, "_addr"},  dmem_bus.dmem_address, 0);
        chk({tag, "_wdata"}, dmem_bus.dmem_wdata, 0);
        chk({tag, "_mbe"},   32'(dmem_bus.dmem_mbe), 0);
        chk({tag, "_ld"},    load_data, 0);
        chk({tag, "_mis"},   32'(misalign), 0);
    endtask

    // Entered #1 after a posedge with the DUT in IDLE; leaves #1 after the DONE->IDLE edge
    // with req_valid still high, so a re-issue from DONE would show up as cache traffic.
    task automatic run_vec(input vec_t v, input int idx);
        int   busy;
        logic exp_rd, exp_wr;
        exp_rd = v.rd;
        exp_wr = v.wr & ~v.rd;
        req_valid = 1'b1; mem_read_d = v.rd; mem_write_d = v.wr;
        load_funct3 = v.lf3; store_funct3 = v.sf3; addr = v.addr; store_data = v.sdata;
        #1;
        chk($sformatf("v%0d_stall_accept", idx), 32'(stall), 1);
        chk($sformatf("v%0d_rd_idle", idx), 32'(dmem_bus.dmem_read), 0);
        @(posedge clk); #1;
        busy = 0;
        while (!done && busy < 20) begin
            chk($sformatf("v%0d_stall_busy%0d", idx, busy), 32'(stall), 1);
            chk($sformatf("v%0d_rd_busy%0d", idx, busy), 32'(dmem_bus.dmem_read), 32'(exp_rd));
            chk($sformatf("v%0d_wr_busy%0d", idx, busy), 32'(dmem_bus.dmem_write), 32'(exp_wr));
            chk($sformatf("v%0d_addr_busy%0d", idx, busy), dmem_bus.dmem_address, v.e_addr);
            chk($sformatf("v%0d_mbe_busy%0d", idx, busy), 32'(dmem_bus.dmem_mbe), 32'(v.e_mbe));
            chk($sformatf("v%0d_wdata_busy%0d", idx, busy), dmem_bus.dmem_wdata, v.e_wdata);
            if (busy == v.waits) begin
                dmem_bus.dmem_resp  = 1'b1;
                dmem_bus.dmem_rdata = v.rdata;
            end
            @(posedge clk); #1;
            dmem_bus.dmem_resp  = 1'b0;
            dmem_bus.dmem_rdata = $urandom;
            busy++;
        end
        chk($sformatf("v%0d_busy_cycles", idx), 32'(busy), 32'(v.waits + 1));
        chk($sformatf("v%0d_done", idx), 32'(done), 1);
        chk($sformatf("v%0d_stall_done", idx), 32'(stall), 0);
        chk($sformatf("v%0d_load_data", idx), load_data, v.e_ld);
        chk($sformatf("v%0d_rd_done", idx), 32'(dmem_bus.dmem_read), 0);
        chk($sformatf("v%0d_wr_done", idx), 32'(dmem_bus.dmem_write), 0);
        chk($sformatf("v%0d_mis_done", idx), 32'(misalign), 0);
        $display("txn %0d: rd=%0b wr=%0b addr=%h busy=%0d load_data=%h", idx, v.rd, v.wr, v.addr, busy, load_data);
        @(posedge clk); #1;
        chk($sformatf("v%0d_no_reissue_rd", idx), 32'(dmem_bus.dmem_read), 0);
        chk($sformatf("v%0d_no_reissue_wr", idx), 32'(dmem_bus.dmem_write), 0);
        chk($sformatf("v%0d_done_cleared", idx), 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;

        //            rd    wr    lf3     sf3     addr          sdata         rdata         w  ch    e_addr        e_mbe    e_wdata       e_ld
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 32'h0000_1004, 4'b0000, 32'h0,        32'hDEAD_BEEF));
        vecs.push_back(mk(1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80));
        vecs.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       1, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_2001, 32'h0000_00FF, 32'h0,       0, 1'b0, 32'h0000_2000, 4'b0010, 32'h0000_FF00, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_3000, 32'h0,        32'h1234_5678, 0, 1'b1, 32'h0000_3000, 4'b0000, 32'h0,        32'h1234_5678));
        vecs.push_back(mk(1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_4002, 32'h0,        32'h8001_7FFF, 0, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'hFFFF_8001));
        vecs.push_back(mk(1'b1, 1'b0, 3'b101, 3'b000, 32'h0000_4000, 32'h0,        32'h8001_F00F, 3, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'h0000_F00F));
        vecs.push_back(mk(1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_4000, 32'h0,        32'h0000_7ABC, 0, 1'b1, 32'h0000_4000, 4'b0000, 32'h0,        32'h0000_7ABC));
        vecs.push_back(mk(1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_5001, 32'h0,        32'h0000_7F00, 0, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_007F));
        vecs.push_back(mk(1'b1, 1'b1, 3'b010, 3'b010, 32'h0000_6008, 32'h1111_1111, 32'hCAFE_F00D, 1, 1'b0, 32'h0000_6008, 4'b0000, 32'h0,       32'hCAFE_F00D));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_7000, 32'h0102_0304, 32'h0,       0, 1'b0, 32'h0000_7000, 4'b1111, 32'h0102_0304, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b011, 32'h0000_7004, 32'hAABB_CCDD, 32'h0,       0, 1'b1, 32'h0000_7004, 4'b1111, 32'hAABB_CCDD, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b111, 3'b000, 32'h0000_7008, 32'h0,        32'h55AA_55AA, 0, 1'b0, 32'h0000_7008, 4'b0000, 32'h0,        32'h55AA_55AA));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_7003, 32'h0000_00A5, 32'h0,       0, 1'b0, 32'h0000_7000, 4'b1000, 32'hA500_0000, 32'h0));
`ifndef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_1002, 32'h0,        32'h1122_3344, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h1122_3344));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'h0,       0, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000_BEEF, 32'h0));
`endif

        #12;
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        // Non-memory instruction passes without a stall.
        req_valid = 1'b1; mem_read_d = 1'b0; mem_write_d = 1'b0; addr = 32'h0000_0ABC;
        #1;
        chk("nonmem_stall", 32'(stall), 0);
        @(posedge clk); #1;
        chk("nonmem_rd", 32'(dmem_bus.dmem_read), 0);
        chk("nonmem_wr", 32'(dmem_bus.dmem_write), 0);
        req_valid = 1'b0;
        $display("txn nonmem: stall=%0b", stall);

        // Stray response in IDLE is ignored.
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        dmem_bus.dmem_resp = 1'b0;
        chk("stray_done", 32'(done), 0);
        chk("stray_stall", 32'(stall), 0);
        chk("stray_ld", load_data, 0);
        $display("txn stray_resp: done=%0b", done);

        foreach (vecs[i]) begin
            if (!vecs[i].chain) begin
                req_valid = 1'b0;
                #1;
                chk($sformatf("v%0d_gap_stall", i), 32'(stall), 0);
                @(posedge clk); #1;
                chk($sformatf("v%0d_gap_rd", i), 32'(dmem_bus.dmem_read), 0);
            end
            run_vec(vecs[i], i);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a BUSY read.
        req_valid = 1'b1; mem_read_d = 1'b1; mem_write_d = 1'b0;
        load_funct3 = 3'b010; addr = 32'h0000_8000;
        @(posedge clk); #1;
        chk("rst_busy_rd", 32'(dmem_bus.dmem_read), 1);
        chk("rst_busy_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        $display("txn async_reset: dmem_read=%0b stall=%0b", dmem_bus.dmem_read, stall);
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("rst_held");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], 100);
        req_valid = 1'b0;
        @(posedge clk); #1;

`ifdef MISALIGN_TRAP_EN
        req_valid = 1'b1; mem_read_d = 1'b1; mem_write_d = 1'b0;
        load_funct3 = 3'b010; addr = 32'h0000_1002;
        #1;
        chk("mis_stall_accept", 32'(stall), 1);
        @(posedge clk); #1;
        chk("mis_done", 32'(done), 1);
        chk("mis_flag", 32'(misalign), 1);
        chk("mis_ld", load_data, 0);
        chk("mis_rd", 32'(dmem_bus.dmem_read), 0);
        chk("mis_stall_done", 32'(stall), 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mis_flag_clear", 32'(misalign), 0);
        chk("mis_done_clear", 32'(done), 0);
        $display("txn misaligned_lw: done/misalign pulse observed");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
